lpc_frame_sequencer: RTL and testbench

- Sequences one lpc_encode core per frame: streams FRAME_LEN input samples into the core's x buffer, pulses start, waits for rready, then drains ORDER coefficients and FRAME_LEN residues onto a single output stream.
- Replaces software polling over the memory-mapped bus with a streaming front end.
- Sits between the audio sample source and the downstream packer.

---
 rtl/lpc_pkg.sv | 25 ++
 rtl/lpc_seq_rdport.sv | 59 +++++
 rtl/lpc_frame_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_lpc_frame_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared types and defaults for the LPC frame sequencer.
package lpc_pkg;

  localparam int unsigned LPC_FRAME_LEN = 160;
  localparam int unsigned LPC_ORDER     = 10;

  typedef enum logic [2:0] {
    StFill,
    StStart,
    StWait,
    StCoef,
    StRes
  } seq_state_e;

  typedef enum logic {
    OutRes  = 1'b0,
    OutCoef = 1'b1
  } out_kind_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lpc_seq_rdport.sv
// Latency-matched read port: waits RD_LAT cycles after an address is presented, captures the
// returned word and holds it until the valid/ready handshake completes.
module lpc_seq_rdport
  import lpc_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_i,
  input  logic [31:0] rdata_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        done_o
);

  localparam int unsigned LatW = clog2_min1(RD_LAT + 1);

  logic [LatW-1:0] lat_q, lat_d;
  logic            valid_q, valid_d;
  logic [31:0]     data_q, data_d;

  always_comb begin
    lat_d   = lat_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (valid_q) begin
      if (ready_i) begin
        valid_d = 1'b0;
      end
    end else if (issue_i) begin
      if (lat_q == LatW'(RD_LAT)) begin
        data_d  = rdata_i;
        valid_d = 1'b1;
        lat_d   = '0;
      end else begin
        lat_d = lat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      lat_q   <= lat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign done_o  = valid_q & ready_i;

endmodule

// File: rtl/lpc_frame_sequencer.sv
// Streams one frame into an lpc_encode core, starts it, then drains coefficients and residues.
// Optional WAIT watchdog and timeout_err port when LPC_SEQ_TIMEOUT_EN is defined.
module lpc_frame_sequencer
  import lpc_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = LPC_FRAME_LEN,
  parameter int unsigned ORDER       = LPC_ORDER,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             enc_start,
  input  logic             enc_rready,
  output logic             enc_x_wen,
  output logic [7:0]       enc_x_waddr,
  output logic [15:0]      enc_x_din,
  output logic [7:0]       enc_residue_raddr,
  input  logic [15:0]      enc_residue_dout,
  output logic [ORDER-1:0] enc_a_rsel,
  input  logic [31:0]      enc_a_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_is_coef,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      frame_count
`ifdef LPC_SEQ_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  localparam int unsigned CntW = clog2_min1(FRAME_LEN);
  localparam int unsigned KW   = clog2_min1(ORDER);

  if (FRAME_LEN < 1 || FRAME_LEN > 256) begin : g_bad_frame_len
    $error("FRAME_LEN must be in 1..256");
  end
  if (ORDER < 1 || ORDER > 32) begin : g_bad_order
    $error("ORDER must be in 1..32");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic            skip_q, skip_d;
  logic [15:0]     frame_q, frame_d;

`ifdef LPC_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = clog2_min1(TIMEOUT_CYC);
  logic [WdW-1:0] wd_q, wd_d;
  logic           tmo_q, tmo_d;
`endif

  logic        accept;
  logic        rd_issue, rd_valid, rd_done;
  logic [31:0] rd_rdata, rd_data;
  out_kind_e   kind;

  assign in_ready = (state_q == StFill) & enable & ~reset;
  assign accept   = in_valid & in_ready;

  assign kind     = (state_q == StCoef) ? OutCoef : OutRes;
  assign rd_issue = (state_q == StCoef) || (state_q == StRes);
  assign rd_rdata = (kind == OutCoef) ? enc_a_dout
                                      : {{16{enc_residue_dout[15]}}, enc_residue_dout};

  lpc_seq_rdport #(
    .RD_LAT (RD_LAT)
  ) u_rdport (
    .clk_i   (clock),
    .rst_i   (reset),
    .issue_i (rd_issue),
    .rdata_i (rd_rdata),
    .ready_i (out_ready),
    .valid_o (rd_valid),
    .data_o  (rd_data),
    .done_o  (rd_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    skip_d  = skip_q;
    frame_d = frame_q;
`ifdef LPC_SEQ_TIMEOUT_EN
    wd_d    = wd_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (cnt_q == CntW'(FRAME_LEN - 1)) begin
            cnt_d   = '0;
            state_d = StStart;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StStart: begin
        // The core may still report the previous frame's rready for one cycle.
        skip_d  = 1'b1;
        state_d = StWait;
`ifdef LPC_SEQ_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      StWait: begin
        skip_d = 1'b0;
`ifdef LPC_SEQ_TIMEOUT_EN
        wd_d   = wd_q + 1'b1;
`endif
        if (!skip_q && enc_rready) begin
          k_d     = '0;
          state_d = StCoef;
        end
`ifdef LPC_SEQ_TIMEOUT_EN
        else if (wd_q == WdW'(TIMEOUT_CYC - 1)) begin
          cnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = StFill;
        end
`endif
      end
      StCoef: begin
        if (rd_done) begin
          if (k_q == KW'(ORDER - 1)) begin
            k_d     = '0;
            cnt_d   = '0;
            state_d = StRes;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StRes: begin
        if (rd_done) begin
          if (cnt_q == CntW'(FRAME_LEN - 1)) begin
            cnt_d   = '0;
            frame_d = frame_q + 16'd1;
            state_d = StFill;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StFill;
      cnt_q   <= '0;
      k_q     <= '0;
      skip_q  <= 1'b0;
      frame_q <= '0;
`ifdef LPC_SEQ_TIMEOUT_EN
      wd_q    <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      skip_q  <= skip_d;
      frame_q <= frame_d;
`ifdef LPC_SEQ_TIMEOUT_EN
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign enc_x_wen         = accept;
  assign enc_x_waddr       = accept ? 8'(cnt_q) : 8'd0;
  assign enc_x_din         = accept ? in_data : 16'd0;
  assign enc_start         = (state_q == StStart);
  assign enc_residue_raddr = (state_q == StRes) ? 8'(cnt_q) : 8'd0;
  assign enc_a_rsel        = (state_q == StCoef) ? (ORDER'(1) << k_q) : '0;

  assign out_valid   = rd_valid;
  assign out_data    = rd_data;
  assign out_is_coef = rd_valid && (kind == OutCoef);
  assign out_last    = rd_valid && (state_q == StRes) && (cnt_q == CntW'(FRAME_LEN - 1));
  assign busy        = !((state_q == StFill) && (cnt_q == '0));
  assign frame_count = frame_q;
`ifdef LPC_SEQ_TIMEOUT_EN
  assign timeout_err = tmo_q;
`endif

endmodule

// File: tb/tb_lpc_frame_sequencer.sv
// Directed bench for lpc_frame_sequencer with a behavioural core model and output scoreboard.
// Covers LPC_SEQ_TIMEOUT_EN when that macro is defined.
module tb_lpc_frame_sequencer;

  typedef struct packed {
    logic [31:0] data;
    logic        coef;
    logic        last;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, enable, in_valid, in_ready;
  logic [15:0] in_data;
  logic        enc_start, enc_rready = 1'b0, enc_x_wen;
  logic [7:0]  enc_x_waddr, enc_residue_raddr;
  logic [15:0] enc_x_din, enc_residue_dout = 16'd0;
  logic [9:0]  enc_a_rsel;
  logic [31:0] enc_a_dout = 32'd0, out_data;
  logic        out_valid, out_ready = 1'b0, out_is_coef, out_last, busy;
  logic [15:0] frame_count;
`ifdef LPC_SEQ_TIMEOUT_EN
  logic        timeout_err;
`endif

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   starts   = 0;
  bit   bp_mode  = 1'b0;
  bit   hold_low = 1'b0;

  always #5 clock = ~clock;

  lpc_frame_sequencer #(
    .FRAME_LEN   (160),
    .ORDER       (10),
    .RD_LAT      (1),
    .TIMEOUT_CYC (100)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .enc_start         (enc_start),
    .enc_rready        (enc_rready),
    .enc_x_wen         (enc_x_wen),
    .enc_x_waddr       (enc_x_waddr),
    .enc_x_din         (enc_x_din),
    .enc_residue_raddr (enc_residue_raddr),
    .enc_residue_dout  (enc_residue_dout),
    .enc_a_rsel        (enc_a_rsel),
    .enc_a_dout        (enc_a_dout),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_is_coef       (out_is_coef),
    .out_last          (out_last),
    .busy              (busy),
    .frame_count       (frame_count)
`ifdef LPC_SEQ_TIMEOUT_EN
    ,
    .timeout_err       (timeout_err)
`endif
  );

  function automatic logic [31:0] coef_of(input logic [9:0] sel);
    for (int k = 0; k < 10; k++) begin
      if (sel == (10'd1 << k)) return 32'h1000_0000 + 32'(k);
    end
    return 32'hDEAD_BEEF;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic c, input logic l);
    exp_t e;
    e.data = d;
    e.coef = c;
    e.last = l;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Core model: one-cycle read latency, rready rises 40 cycles after start and stays stale
  // for the first cycle after the start pulse.
  int rdy_cnt = 0;
  always @(posedge clock) begin
    enc_a_dout       <= coef_of(enc_a_rsel);
    enc_residue_dout <= 16'hFFF0 + 16'(enc_residue_raddr);
    if (enc_start) rdy_cnt <= 40;
    else if (rdy_cnt > 0) rdy_cnt <= rdy_cnt - 1;
    if (hold_low) enc_rready <= 1'b0;
    else if (!enc_start && rdy_cnt > 1) enc_rready <= 1'b0;
    else if (!enc_start && rdy_cnt == 1) enc_rready <= 1'b1;
  end

  // Output side: drives out_ready, pops the scoreboard, checks stall stability.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data  = 32'd0;
  always @(negedge clock) begin
    exp_t e;
    out_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    #1;
    if (reset !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (enc_start === 1'b1) starts++;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid === 1'b1 && out_ready) begin
        chk("out_after_rready", enc_rready, 1);
        if (exp_q.size() == 0) begin
          n_assert++;
          n_fail++;
          $error("FAIL extra_word: observed %h expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_is_coef", out_is_coef, e.coef);
          chk("out_last", out_last, e.last);
        end
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_in_ready"}, in_ready, 0);
    chk({pfx, "_enc_start"}, enc_start, 0);
    chk({pfx, "_x_wen"}, enc_x_wen, 0);
    chk({pfx, "_a_rsel"}, enc_a_rsel, 0);
    chk({pfx, "_raddr"}, enc_residue_raddr, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_data"}, out_data, 0);
    chk({pfx, "_out_flags"}, {out_is_coef, out_last}, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_frame_count"}, frame_count, 0);
`ifdef LPC_SEQ_TIMEOUT_EN
    chk({pfx, "_timeout_err"}, timeout_err, 0);
`endif
  endtask

  task automatic send_frame(input logic [15:0] base, input int pause_at, input bit push);
    int b;
    if (push) begin
      for (int k = 0; k < 10; k++) exp_q.push_back(mk(32'h1000_0000 + 32'(k), 1'b1, 1'b0));
      for (int r = 0; r < 160; r++) begin
        logic [15:0] v;
        v = 16'hFFF0 + 16'(r);
        exp_q.push_back(mk(32'($signed(v)), 1'b0, r == 159));
      end
    end
    for (int i = 0; i < 160; i++) begin
      @(negedge clock);
      if (i == pause_at) begin
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = base + 16'(i);
        repeat (20) begin
          #1;
          chk("pause_in_ready", in_ready, 0);
          chk("pause_x_wen", enc_x_wen, 0);
          @(negedge clock);
        end
        enable = 1'b1;
      end
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      #1;
      b = 0;
      while (in_ready !== 1'b1 && b < 5000) begin
        @(negedge clock);
        #1;
        b++;
      end
      chk("in_ready", in_ready, 1);
      chk("x_wen", enc_x_wen, 1);
      chk("x_waddr", enc_x_waddr, i);
      chk("x_din", enc_x_din, base + 16'(i));
    end
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    chk("enc_start", enc_start, 1);
    chk("start_in_ready", in_ready, 0);
  endtask

  task automatic wait_drain(input int target);
    int b;
    b = 0;
    while (frame_count !== 16'(target) && b < 8000) begin
      chk("drain_in_ready", in_ready, 0);
      @(negedge clock);
      #1;
      b++;
    end
    chk("frame_count", frame_count, target);
  endtask

  initial begin
    int b;
    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'd0;
    repeat (2) @(negedge clock);
    #1;
    chk_zero_outputs("reset");
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);

    // Abort a frame with reset while residue 50 is being read.
    send_frame(16'h0100, -1, 1'b1);
    b = 0;
    while (enc_residue_raddr !== 8'd50 && b < 3000) begin
      @(negedge clock);
      #1;
      b++;
    end
    chk("reach_r50", enc_residue_raddr, 50);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready, 1);

    // Ramp frame with out_ready held high.
    starts = 0;
    send_frame(16'h0000, -1, 1'b1);
    wait_drain(1);
    chk("start_count", starts, 1);
    chk("drained_1", exp_q.size(), 0);

    // Three frames under random backpressure, the first paused after 70 samples.
    bp_mode = 1'b1;
    send_frame(16'h0200, 70, 1'b1);
    wait_drain(2);
    send_frame(16'h0300, -1, 1'b1);
    wait_drain(3);
    send_frame(16'h0400, -1, 1'b1);
    wait_drain(4);
    bp_mode = 1'b0;
    chk("drained_bp", exp_q.size(), 0);
    chk("final_busy", busy, 0);

`ifdef LPC_SEQ_TIMEOUT_EN
    hold_low = 1'b1;
    send_frame(16'h0500, -1, 1'b0);
    b = 0;
    while (timeout_err !== 1'b1 && b < 300) begin
      @(negedge clock);
      #1;
      b++;
    end
    chk("timeout_window", (b >= 99 && b <= 101), 1);
    @(negedge clock);
    #1;
    chk("timeout_pulse_end", timeout_err, 0);
    chk("timeout_in_ready", in_ready, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_frame_count", frame_count, 4);
    hold_low = 1'b0;
`endif

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
